// File: rtl/reg_pkg.sv
// Shared operation encodings for the universal register and the Fibonacci control FSM.
package reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/register_nextstate.sv
// Combinational next value and carry for the universal register.
module register_nextstate
  import reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SAT_ARITH = 1'b0
) (
  input  logic [WIDTH-1:0] reg_out,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  input  logic             carry,
  output logic [WIDTH-1:0] reg_nxt,
  output logic             carry_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, reg_out} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = {1'b0, reg_out} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    reg_nxt   = reg_out;
    carry_nxt = carry;
    case (mode)
      MODE_LOAD: begin
        reg_nxt   = par_in;
        carry_nxt = 1'b0;
      end
      MODE_SHL: begin
        reg_nxt   = {reg_out[WIDTH-2:0], ser_in};
        carry_nxt = reg_out[WIDTH-1];
      end
      MODE_SHR: begin
        reg_nxt   = {ser_in, reg_out[WIDTH-1:1]};
        carry_nxt = reg_out[0];
      end
      MODE_ROTL: begin
        reg_nxt   = {reg_out[WIDTH-2:0], reg_out[WIDTH-1]};
        carry_nxt = reg_out[WIDTH-1];
      end
      MODE_ROTR: begin
        reg_nxt   = {reg_out[0], reg_out[WIDTH-1:1]};
        carry_nxt = reg_out[0];
      end
      MODE_INC: begin
        // Overflow shows up in the extra top bit; saturation keeps all-ones.
        carry_nxt = sum[WIDTH];
        reg_nxt   = (sum[WIDTH] && SAT_ARITH) ? reg_out : sum[WIDTH-1:0];
      end
      MODE_DEC: begin
        carry_nxt = diff[WIDTH];
        reg_nxt   = (diff[WIDTH] && SAT_ARITH) ? reg_out : diff[WIDTH-1:0];
      end
      default: begin
        reg_nxt   = reg_out;
        carry_nxt = carry;
      end
    endcase
  end

endmodule

// File: rtl/register_universal.sv
// Parametrised register with load/shift/rotate/inc/dec and a registered carry flag.
module register_universal
  import reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter bit               SAT_ARITH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] reg_out,
  output logic             carry,
  output logic             ser_out,
  output logic             zero
);

  logic [WIDTH-1:0] reg_nxt;
  logic             carry_nxt;

  register_nextstate #(
    .WIDTH     (WIDTH),
    .SAT_ARITH (SAT_ARITH)
  ) u_nextstate (
    .reg_out   (reg_out),
    .mode      (mode),
    .par_in    (par_in),
    .ser_in    (ser_in),
    .carry     (carry),
    .reg_nxt   (reg_nxt),
    .carry_nxt (carry_nxt)
  );

  // Gating on en keeps an undriven mode from ever reaching the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_out <= RST_VALUE;
      carry   <= 1'b0;
    end else if (en) begin
      reg_out <= reg_nxt;
      carry   <= carry_nxt;
    end
  end

  assign ser_out = ((mode == MODE_SHL) || (mode == MODE_ROTL)) ? reg_out[WIDTH-1] : reg_out[0];
  assign zero    = (reg_out == '0);

endmodule

// File: tb/tb_register_universal.sv
// Scoreboard bench: wrap-mode and saturate-mode instances driven by directed vectors.
module tb_register_universal;
  import reg_pkg::*;

  typedef struct {
    int         d;
    logic [7:0] er;
    logic       ec;
    logic       ez;
    logic       es;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, en0, ser0, rst1, en1, ser1;
  logic [2:0] mode0, mode1;
  logic [7:0] par0, par1;
  logic [7:0] q0, q1;
  logic       c0, c1, so0, so1, z0, z1;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  always #5 clk = ~clk;

  register_universal #(.WIDTH(8), .RST_VALUE(8'h01), .SAT_ARITH(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .en(en0), .mode(mode0), .par_in(par0), .ser_in(ser0),
    .reg_out(q0), .carry(c0), .ser_out(so0), .zero(z0));

  register_universal #(.WIDTH(8), .RST_VALUE(8'h01), .SAT_ARITH(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .en(en1), .mode(mode1), .par_in(par1), .ser_in(ser1),
    .reg_out(q1), .carry(c1), .ser_out(so1), .zero(z1));

  task automatic cmp(input string nm, input string field, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  // Monitor: compares every pending expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.d == 0) begin
          cmp(e.nm, "reg", q0, e.er);
          cmp(e.nm, "carry", {7'd0, c0}, {7'd0, e.ec});
          cmp(e.nm, "zero", {7'd0, z0}, {7'd0, e.ez});
          cmp(e.nm, "ser_out", {7'd0, so0}, {7'd0, e.es});
        end else begin
          cmp(e.nm, "reg", q1, e.er);
          cmp(e.nm, "carry", {7'd0, c1}, {7'd0, e.ec});
          cmp(e.nm, "zero", {7'd0, z1}, {7'd0, e.ez});
          cmp(e.nm, "ser_out", {7'd0, so1}, {7'd0, e.es});
        end
      end
    end
  end

  task automatic step(input int d, input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] p, input logic s, input logic [7:0] er,
                      input logic ec, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    if (d == 0) begin
      rst0 = r; en0 = e; mode0 = m; par0 = p; ser0 = s;
      rst1 = 1'b0; en1 = 1'b0;
    end else begin
      rst1 = r; en1 = e; mode1 = m; par1 = p; ser1 = s;
      rst0 = 1'b0; en0 = 1'b0;
    end
    @(posedge clk);
    #1;
    x.d  = d;
    x.er = er;
    x.ec = ec;
    x.ez = (er == 8'h00);
    x.es = ((m == MODE_SHL) || (m == MODE_ROTL)) ? er[7] : er[0];
    x.nm = nm;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    rst0 = 1'b1; en0 = 1'b0; mode0 = MODE_HOLD; par0 = 8'h00; ser0 = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; mode1 = MODE_HOLD; par1 = 8'h00; ser1 = 1'b0;

    // Reset and idle hold with mode left undriven
    step(0, 1'b1, 1'b0, MODE_INC, 8'h00, 1'b0, 8'h01, 1'b0, "reset0");
    step(0, 1'b1, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h01, 1'b0, "reset1");
    for (int i = 0; i < 3; i++)
      step(0, 1'b0, 1'b0, 3'bxxx, 8'hFF, 1'b1, 8'h01, 1'b0, "idle");

    // Load then shift
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, "load_a5");
    step(0, 1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 8'h4B, 1'b1, "shl");
    step(0, 1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0, 8'h25, 1'b1, "shr");

    // Rotate full circle
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, "load_81");
    step(0, 1'b0, 1'b1, MODE_ROTL, 8'h00, 1'b0, 8'h03, 1'b1, "rotl_first");
    rv = 8'h03;
    for (int i = 0; i < 6; i++) begin
      rv = {rv[6:0], 1'b0};
      step(0, 1'b0, 1'b1, MODE_ROTL, 8'h00, 1'b0, rv, 1'b0, "rotl_mid");
    end
    step(0, 1'b0, 1'b1, MODE_ROTL, 8'h00, 1'b0, 8'h81, 1'b1, "rotl_last");
    step(0, 1'b0, 1'b1, MODE_ROTR, 8'h00, 1'b0, 8'hC0, 1'b1, "rotr");

    // Increment / decrement wrap
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 8'hFE, 1'b0, "load_fe");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'hFF, 1'b0, "inc_ff");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h00, 1'b1, "inc_wrap");
    step(0, 1'b0, 1'b1, MODE_HOLD, 8'h55, 1'b1, 8'h00, 1'b1, "hold_carry");
    step(0, 1'b0, 1'b0, MODE_LOAD, 8'h55, 1'b1, 8'h00, 1'b1, "en0_carry");
    step(0, 1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 8'hFF, 1'b1, "dec_wrap");
    step(0, 1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 8'hFE, 1'b0, "dec_fe");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'hFF, 1'b0, "inc_back");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h00, 1'b1, "inc_wrap2");
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, "load_clr_c");

    // Saturating instance
    step(1, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 8'h01, 1'b0, "s_reset");
    step(1, 1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0, 8'h01, 1'b0, "s_load_01");
    step(1, 1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 8'h00, 1'b0, "s_dec_00");
    step(1, 1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 8'h00, 1'b1, "s_dec_sat");
    step(1, 1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0, "s_load_ff");
    step(1, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'hFF, 1'b1, "s_inc_sat");
    step(1, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'hFF, 1'b1, "s_inc_sat2");
    step(1, 1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0, 8'hFE, 1'b0, "s_dec_fe");

    // Reset mid-stream on the wrap instance
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'h35, 1'b0, 8'h35, 1'b0, "m_load_35");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h36, 1'b0, "m_inc_36");
    step(0, 1'b0, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h37, 1'b0, "m_inc_37");
    step(0, 1'b1, 1'b1, MODE_INC, 8'h00, 1'b0, 8'h01, 1'b0, "m_reset");
    step(0, 1'b0, 1'b1, MODE_LOAD, 8'h10, 1'b0, 8'h10, 1'b0, "m_load_10");

    // Saturating instance untouched while the other ran
    step(1, 1'b0, 1'b0, MODE_INC, 8'h00, 1'b0, 8'hFE, 1'b0, "s_kept");

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    done = 1'b1;
    $finish;
  end

endmodule
